// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit_pkg
//  Description : Shared funct3 size codes and FSM state encoding for the
//                load/store unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

    // Access size / extension codes carried in funct3
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit_if
//  Description : Data-memory req/ack port. The LSU is the master; the memory
//                (or a bench model) is the slave.
//  Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/load_store_unit_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_align
//  Description : Combinational lane logic: store byte-enables and lane
//                replication, load byte/half extraction with sign/zero
//                extension, and illegal size/alignment decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import load_store_unit_pkg::*;
(
    input  wire logic [1:0]  addr_lo_i,
    input  wire logic [2:0]  funct3_i,
    input  wire logic        mem_read_i,
    input  wire logic        mem_write_i,
    input  wire logic [31:0] wdata_i,
    input  wire logic [31:0] rword_i,
    output logic [3:0]       be_o,
    output logic [31:0]      wdata_o,
    output logic [31:0]      rdata_o,
    output logic             misaligned_o
);

    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_illegal_f3;

    // Byte lane selected by the low address bits; halves sit on bit 1
    assign w_shifted = rword_i >> {addr_lo_i, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_half    = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

    // Store lanes: small stores are replicated so every lane carries the data
    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_o    = 4'b0011 << addr_lo_i;
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
            end
        endcase
    end

    // Load extraction with sign or zero extension
    always_comb begin
        rdata_o = rword_i;
        case (funct3_i)
            F3_B:    rdata_o = {{24{w_byte[7]}}, w_byte};
            F3_BU:   rdata_o = {24'd0, w_byte};
            F3_H:    rdata_o = {{16{w_half[15]}}, w_half};
            F3_HU:   rdata_o = {16'd0, w_half};
            default: rdata_o = rword_i;
        endcase
    end

    // Reserved size codes are 011, 110 and 111
    assign w_illegal_f3 = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);

    // Unsigned encodings are load-only, so a store with funct3[2] set is illegal
    assign misaligned_o = (mem_read_i & mem_write_i)
                        | (((funct3_i == F3_H) || (funct3_i == F3_HU)) & addr_lo_i[0])
                        | ((funct3_i == F3_W) & (addr_lo_i != 2'b00))
                        | w_illegal_f3
                        | (mem_write_i & funct3_i[2]);

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Memory stage. Issues a registered req/ack data-memory access
//                for loads and stores, stalls the core until it completes,
//                and aborts with a fault if no ack arrives within TIMEOUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic [31:0] addr_i,
    input  wire logic [31:0] wdata_i,
    input  wire logic [2:0]  funct3_i,
    input  wire logic        mem_read_i,
    input  wire logic        mem_write_i,
    output logic             stall_o,
    output logic [31:0]      rdata_o,
    output logic             misaligned_o,
    output logic             fault_o,
    load_store_unit_if.master mem
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             fault_q, fault_d;
    logic             req_q,   req_d;
    logic             we_q,    we_d;
    logic [31:0]      addr_q,  addr_d;
    logic [3:0]       be_q,    be_d;
    logic [31:0]      wdata_q, wdata_d;

    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [31:0]      w_rdata;
    logic             w_misaligned;
    logic             w_access;

    // Inputs are held stable while stalled, so the live address/funct3 are
    // still valid when the load data returns in REQ.
    lsu_align u_align (
        .addr_lo_i    (addr_i[1:0]),
        .funct3_i     (funct3_i),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .wdata_i      (wdata_i),
        .rword_i      (mem.mem_rdata),
        .be_o         (w_be),
        .wdata_o      (w_wdata),
        .rdata_o      (w_rdata),
        .misaligned_o (w_misaligned)
    );

    assign w_access     = (mem_read_i | mem_write_i) & ~w_misaligned;
    assign misaligned_o = w_misaligned;
    assign stall_o      = ((state_q == IDLE) & w_access) | (state_q == REQ);
    assign rdata_o      = rdata_q;
    assign fault_o      = fault_q;

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = wdata_q;

    // State and registered memory-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state: launch in IDLE, wait for ack or timeout in REQ, one DONE beat
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (w_access) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    we_d    = mem_write_i;
                    addr_d  = {addr_i[31:2], 2'b00};
                    be_d    = w_be;
                    wdata_d = w_wdata;
                    cnt_d   = '0;
                end
            end
            REQ: begin
                if (mem.mem_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        rdata_d = w_rdata;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    fault_d = 1'b1;
                    rdata_d = '0;
                    req_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                fault_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Directed bench for load_store_unit. Stimulus pushes the
//                expected transaction into a scoreboard queue; a monitor
//                compares the request and completion it observes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        fault;
        int          req_cyc;
        logic        aborted;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic        mem_read;
    logic        mem_write;
    logic        stall;
    logic [31:0] rdata;
    logic        misaligned;
    logic        fault;
    logic        ack_resp;
    logic        ack_late;
    logic [31:0] rword;

    int   n_checks   = 0;
    int   n_fail     = 0;
    int   done_count = 0;
    int   cfg_wait   = 0;
    exp_t sb[$];

    load_store_unit_if bus ();
    assign bus.mem_ack   = ack_resp | ack_late;
    assign bus.mem_rdata = rword;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .funct3_i     (funct3),
        .mem_read_i   (mem_read),
        .mem_write_i  (mem_write),
        .stall_o      (stall),
        .rdata_o      (rdata),
        .misaligned_o (misaligned),
        .fault_o      (fault),
        .mem          (bus.master)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory model: ack after cfg_wait wait states (negative = never)
    initial begin
        int wc;
        wc       = 0;
        ack_resp = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_req && !rst) begin
                if (cfg_wait >= 0 && wc == cfg_wait) begin
                    ack_resp = 1'b1;
                end else begin
                    ack_resp = 1'b0;
                    wc++;
                end
            end else begin
                ack_resp = 1'b0;
                wc       = 0;
            end
        end
    end

    // Monitor: checks each request as it is raised and each completion
    initial begin
        logic prev_req;
        logic prev_stall;
        logic chk_fault_clear;
        int   req_cyc;
        int   stall_cyc;
        exp_t e;
        prev_req        = 1'b0;
        prev_stall      = 1'b0;
        chk_fault_clear = 1'b0;
        req_cyc         = 0;
        stall_cyc       = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (sb.size() > 0 && sb[0].aborted) begin
                    e = sb.pop_front();
                end
                prev_req        = 1'b0;
                prev_stall      = 1'b0;
                chk_fault_clear = 1'b0;
                req_cyc         = 0;
                stall_cyc       = 0;
            end else begin
                if (chk_fault_clear) begin
                    check("fault_clears", 32'(fault), 32'd0);
                    chk_fault_clear = 1'b0;
                end
                if (bus.mem_req) begin
                    if (!prev_req) begin
                        if (sb.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_req: got addr 0x%08h, expected no request", bus.mem_addr);
                        end else begin
                            e = sb[0];
                            check("req_we",   32'(bus.mem_we), 32'(e.we));
                            check("req_addr", bus.mem_addr,    e.addr);
                            if (e.we) begin
                                check("req_be",    32'(bus.mem_be), 32'(e.be));
                                check("req_wdata", bus.mem_wdata,   e.wdata);
                            end
                        end
                    end
                    req_cyc++;
                end
                if (stall) begin
                    stall_cyc++;
                end
                if (prev_stall && !stall) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_done: got completion, expected none");
                    end else begin
                        e = sb.pop_front();
                        check("done_rdata",     rdata,              e.rdata);
                        check("done_fault",     32'(fault),         32'(e.fault));
                        check("done_req_low",   32'(bus.mem_req),   32'd0);
                        check("req_cycles",     32'(req_cyc),       32'(e.req_cyc));
                        check("stall_cycles",   32'(stall_cyc),     32'(e.req_cyc + 1));
                    end
                    chk_fault_clear = 1'b1;
                    done_count++;
                    req_cyc   = 0;
                    stall_cyc = 0;
                end
                prev_req   = bus.mem_req;
                prev_stall = stall;
            end
        end
    end

    task automatic do_access(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                             input logic wr, input int wt, input logic [31:0] word,
                             input logic [31:0] x_addr, input logic [3:0] x_be,
                             input logic [31:0] x_wdata, input logic [31:0] x_rdata,
                             input logic x_fault, input int x_req);
        exp_t e;
        int   start;
        int   n;
        e.we      = wr;
        e.addr    = x_addr;
        e.be      = x_be;
        e.wdata   = x_wdata;
        e.rdata   = x_rdata;
        e.fault   = x_fault;
        e.req_cyc = x_req;
        e.aborted = 1'b0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        mem_read  = ~wr;
        mem_write = wr;
        cfg_wait  = wt;
        rword     = word;
        start     = done_count;
        n         = 0;
        while (done_count == start && n < 60) begin
            @(posedge clk);
            n++;
        end
        if (done_count == start) begin
            n_checks++;
            n_fail++;
            $display("FAIL access_wait: got no completion at addr 0x%08h, expected one within 60 cycles", a);
        end
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        exp_t ab;
        rst       = 1'b1;
        addr      = '0;
        wdata     = '0;
        funct3    = F3_B;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ack_late  = 1'b0;
        rword     = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall",      32'(stall),          32'd0);
        check("rst_rdata",      rdata,               32'd0);
        check("rst_fault",      32'(fault),          32'd0);
        check("rst_mem_req",    32'(bus.mem_req),    32'd0);
        check("rst_mem_we",     32'(bus.mem_we),     32'd0);
        check("rst_mem_addr",   bus.mem_addr,        32'd0);
        check("rst_mem_be",     32'(bus.mem_be),     32'd0);
        check("rst_mem_wdata",  bus.mem_wdata,       32'd0);
        check("rst_misaligned", 32'(misaligned),     32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Stores and loads, with and without wait states
        do_access(F3_W,  32'h100, 32'hDEADBEEF, 1'b1, 0, 32'h0,        32'h100, 4'b1111, 32'hDEADBEEF, 32'h0,        1'b0, 1);
        do_access(F3_B,  32'h203, 32'h0,        1'b0, 0, 32'h80FF0000, 32'h200, 4'b0000, 32'h0,        32'hFFFFFF80, 1'b0, 1);
        do_access(F3_BU, 32'h203, 32'h0,        1'b0, 2, 32'h80FF0000, 32'h200, 4'b0000, 32'h0,        32'h00000080, 1'b0, 3);
        do_access(F3_HU, 32'h202, 32'h0,        1'b0, 0, 32'h80FF0000, 32'h200, 4'b0000, 32'h0,        32'h000080FF, 1'b0, 1);
        do_access(F3_H,  32'h202, 32'h0,        1'b0, 1, 32'h80FF0000, 32'h200, 4'b0000, 32'h0,        32'hFFFF80FF, 1'b0, 2);
        do_access(F3_W,  32'h204, 32'h0,        1'b0, 0, 32'h12345678, 32'h204, 4'b0000, 32'h0,        32'h12345678, 1'b0, 1);
        do_access(F3_B,  32'h11,  32'hAB,       1'b1, 0, 32'h0,        32'h10,  4'b0010, 32'hABABABAB, 32'h12345678, 1'b0, 1);
        do_access(F3_H,  32'h12,  32'h1234,     1'b1, 1, 32'h0,        32'h10,  4'b1100, 32'h12341234, 32'h12345678, 1'b0, 2);

        // Timeout: no ack ever arrives
        do_access(F3_W,  32'h300, 32'h0,        1'b0, -1, 32'h55555555, 32'h300, 4'b0000, 32'h0,       32'h0,        1'b1, 16);
        do_access(F3_W,  32'h304, 32'h0,        1'b0, 0, 32'hCAFEF00D, 32'h304, 4'b0000, 32'h0,        32'hCAFEF00D, 1'b0, 1);

        // Illegal accesses issue no request and do not stall
        @(posedge clk);
        #1;
        funct3 = F3_W; addr = 32'h102; mem_read = 1'b1;
        #1;
        check("mis_lw_unaligned", 32'(misaligned), 32'd1);
        check("mis_lw_stall",     32'(stall),      32'd0);
        @(negedge clk);
        check("mis_lw_req0",      32'(bus.mem_req), 32'd0);
        @(negedge clk);
        check("mis_lw_req1",      32'(bus.mem_req), 32'd0);
        @(posedge clk);
        #1;
        addr = 32'h100; mem_write = 1'b1;
        #1;
        check("mis_rd_and_wr",    32'(misaligned), 32'd1);
        check("mis_rw_stall",     32'(stall),      32'd0);
        @(posedge clk);
        #1;
        mem_write = 1'b0; funct3 = 3'b011; addr = 32'h0;
        #1;
        check("mis_f3_011",       32'(misaligned), 32'd1);
        @(posedge clk);
        #1;
        mem_read = 1'b0; mem_write = 1'b1; funct3 = F3_BU;
        #1;
        check("mis_store_unsigned", 32'(misaligned), 32'd1);
        @(posedge clk);
        #1;
        mem_read = 1'b1; mem_write = 1'b0; funct3 = F3_HU; addr = 32'h201;
        #1;
        check("mis_hu_odd",       32'(misaligned), 32'd1);
        @(posedge clk);
        #1;
        funct3 = F3_W; addr = 32'h100;
        #1;
        check("legal_lw_mis",     32'(misaligned), 32'd0);
        check("legal_lw_stall",   32'(stall),      32'd1);
        #1;
        mem_read = 1'b0;

        // Reset in the middle of an access, then a stray ack
        ab.we = 1'b0; ab.addr = 32'h400; ab.be = 4'b0000; ab.wdata = 32'h0;
        ab.rdata = 32'h0; ab.fault = 1'b0; ab.req_cyc = 0; ab.aborted = 1'b1;
        sb.push_back(ab);
        @(posedge clk);
        #1;
        funct3 = F3_W; addr = 32'h400; mem_read = 1'b1; cfg_wait = -1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1; mem_read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_req",   32'(bus.mem_req), 32'd0);
        check("midrst_stall", 32'(stall),       32'd0);
        check("midrst_rdata", rdata,            32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; ack_late = 1'b1;
        @(negedge clk);
        check("lateack_req",   32'(bus.mem_req), 32'd0);
        check("lateack_stall", 32'(stall),       32'd0);
        @(posedge clk);
        #1;
        ack_late = 1'b0;
        @(negedge clk);
        check("lateack_req2",  32'(bus.mem_req), 32'd0);
        check("lateack_fault", 32'(fault),       32'd0);
        check("lateack_rdata", rdata,            32'd0);

        // Recovery after reset
        do_access(F3_W, 32'h8, 32'h55AA55AA, 1'b1, 0, 32'h0, 32'h8, 4'b1111, 32'h55AA55AA, 32'h0, 1'b0, 1);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
